uart_receiver: RTL and testbench

//  Serial receive half of the UART peripheral. Oversamples rxd with the shared
//  16x baud enable (bclk). Reassembles 8N1/8E1/8O1 frames and checks parity and

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_receiver_if.sv | 26 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_receiver.sv | 149 ++++++++++++++
 tb/tb_uart_receiver.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type, bit timing constants and
// the FIFO threshold helper used by both the RX and TX halves.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

   localparam int BCLK_PER_BIT = 16;
   localparam int SAMPLE_PT    = 7;

   // Threshold select: 00 >8, 01 >6, 10 >4, 11 >2 entries.
   function automatic logic thr_hit(input logic [4:0] count, input logic [1:0] sel);
      logic [4:0] lim;
      case (sel)
         2'b00:   lim = 5'd8;
         2'b01:   lim = 5'd6;
         2'b10:   lim = 5'd4;
         default: lim = 5'd2;
      endcase
      return count > lim;
   endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Bus-side view of the UART receiver: FIFO pop, threshold select, error
// clear, and the head-of-FIFO word with its flags and status.
//  master: register block (drives read_en, rx_thr_val, err_clr)
//  slave : uart_receiver (drives data, error flags and FIFO status)
interface uart_receiver_if;
   logic       read_en;
   logic [1:0] rx_thr_val;
   logic       err_clr;
   logic [7:0] data_out;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       rx_empty;
   logic       rx_full;
   logic       rx_thr;

   modport master (
      output read_en, rx_thr_val, err_clr,
      input  data_out, parity_err, frame_err, overrun, rx_empty, rx_full, rx_thr
   );

   modport slave (
      input  read_en, rx_thr_val, err_clr,
      output data_out, parity_err, frame_err, overrun, rx_empty, rx_full, rx_thr
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received words.
//  clk, resetn : clock, synchronous active-low reset
//  push, push_data : write request and word
//  pop         : read request (ignored when empty)
//  head        : current head word, 0 when empty
//  count       : occupancy 0..DEPTH
//  empty, full : status
//  drop        : push refused because FIFO full and not popping
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 10
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       drop
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   // Pointers carry an extra wrap bit to tell full from empty.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop & ~empty;
   // A pop in the same clk frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;
   assign count   = wr_ptr - rd_ptr;
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/uart_receiver.sv
// UART serial receiver: synchronises rxd, reassembles 8N1/8E1/8O1 frames on
// a 16x baud tick, checks parity/stop and queues {ferr,perr,data} in a FIFO.
//  clk, resetn      : clock, synchronous active-low reset
//  bclk             : one-clk 16x baud tick
//  rxd              : asynchronous serial input, idles high
//  rx_en            : receiver enable; low aborts any frame in progress
//  parity_en        : frame carries a parity bit after D7
//  parity_type      : 1 odd, 0 even
//  rx_bclk_en       : high while a frame is being received
//  bus (slave)      : FIFO head/flags/status, pop, threshold select, err_clr
module uart_receiver #(
   parameter int FIFO_DEPTH   = 16,
   parameter int BCLK_PER_BIT = uart_pkg::BCLK_PER_BIT,
   parameter int SAMPLE_PT    = uart_pkg::SAMPLE_PT
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             bclk,
   input  logic             rxd,
   input  logic             rx_en,
   input  logic             parity_en,
   input  logic             parity_type,
   output logic             rx_bclk_en,
   uart_receiver_if.slave   bus
);
   import uart_pkg::*;

   localparam logic [3:0] CNT_LAST = 4'(BCLK_PER_BIT - 1);
   localparam logic [3:0] CNT_SMP  = 4'(SAMPLE_PT);
   localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

   logic         rxd_m, rxd_s, rxd_q;
   logic         fall;
   rx_state_t    state;
   logic [3:0]   cnt;
   logic [2:0]   bit_idx;
   logic [7:0]   shreg;
   logic         par_en_q, par_type_q, perr_q;
   logic         push;
   logic [9:0]   push_word;
   logic         smp_now, last_now;
   logic [9:0]   head;
   logic [CW-1:0] count;
   logic         drop;

   // Two-flop synchroniser plus one delayed copy for edge detection.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
         rxd_q <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
         rxd_q <= rxd_s;
      end
   end

   assign fall     = rxd_q & ~rxd_s;
   assign smp_now  = bclk && (cnt == CNT_SMP);
   assign last_now = bclk && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         perr_q     <= 1'b0;
         push       <= 1'b0;
      end else begin
         push <= 1'b0;
         if (!rx_en) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            if (state != IDLE && bclk) cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;
            case (state)
               IDLE: if (fall) begin
                  state      <= START;
                  cnt        <= '0;
                  bit_idx    <= '0;
                  par_en_q   <= parity_en;
                  par_type_q <= parity_type;
                  perr_q     <= 1'b0;
               end
               START: begin
                  // Line back high at mid start bit: glitch, not a frame.
                  if (smp_now && rxd_s) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (last_now) begin
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (smp_now) shreg <= {rxd_s, shreg[7:1]};
                  if (last_now) begin
                     if (bit_idx == 3'd7) state <= par_en_q ? PARITY : STOP;
                     else                 bit_idx <= bit_idx + 3'd1;
                  end
               end
               PARITY: begin
                  if (smp_now) perr_q <= rxd_s != (par_type_q ? ~^shreg : ^shreg);
                  if (last_now) state <= STOP;
               end
               STOP: begin
                  // Leave mid stop bit so a back-to-back start edge is not missed.
                  if (smp_now) begin
                     push      <= 1'b1;
                     push_word <= {~rxd_s, perr_q, shreg};
                     state     <= IDLE;
                     cnt       <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign rx_bclk_en = (state != IDLE);

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(10)) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data (push_word),
      .pop       (bus.read_en),
      .head      (head),
      .count     (count),
      .empty     (bus.rx_empty),
      .full      (bus.rx_full),
      .drop      (drop)
   );

   // A drop coinciding with err_clr keeps the flag set.
   always_ff @(posedge clk) begin
      if (!resetn)          bus.overrun <= 1'b0;
      else if (drop)        bus.overrun <= 1'b1;
      else if (bus.err_clr) bus.overrun <= 1'b0;
   end

   assign bus.data_out   = head[7:0];
   assign bus.parity_err = head[8];
   assign bus.frame_err  = head[9];
   assign bus.rx_thr     = thr_hit(5'(count), bus.rx_thr_val);
endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
module tb_uart_receiver;

   logic clk = 1'b0;
   logic resetn;
   logic bclk = 1'b0;
   logic rxd = 1'b1;
   logic rx_en;
   logic parity_en;
   logic parity_type;
   logic rx_bclk_en;

   uart_receiver_if bus();

   uart_receiver dut (
      .clk         (clk),
      .resetn      (resetn),
      .bclk        (bclk),
      .rxd         (rxd),
      .rx_en       (rx_en),
      .parity_en   (parity_en),
      .parity_type (parity_type),
      .rx_bclk_en  (rx_bclk_en),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   // 16x baud tick every 4 clk, changed on the falling edge.
   int div = 0;
   initial forever begin
      @(negedge clk);
      div  = (div + 1) % 4;
      bclk = (div == 0);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int tests = 0;
   int fails = 0;

   // Reference model: queue of {ferr,perr,data} words and the sticky overrun.
   logic [9:0] mq[$];
   bit         m_ovr = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (bclk !== 1'b1);
      end
   endtask

   task automatic build_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic stop, output logic [11:0] bits, output int nb);
      if (pen) begin bits = {1'b1, stop, pbit, d, 1'b0}; nb = 11; end
      else     begin bits = {2'b11, stop, d, 1'b0};      nb = 10; end
   endtask

   task automatic drive_bits(input logic [11:0] bits, input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         @(negedge clk);
         rxd = bits[i];
         wait_ticks(16);
      end
   endtask

   task automatic model_frame(input logic [7:0] d, input logic pen, input logic ptype,
                              input logic pbit, input logic stop);
      int   ones;
      logic want, perr;
      ones = $countones(d);
      // Odd parity makes the total count of ones odd, even makes it even.
      want = ptype ? ((ones % 2) == 0) : ((ones % 2) == 1);
      perr = pen && (pbit != want);
      if (mq.size() == 16) m_ovr = 1'b1;
      else                 mq.push_back({~stop, perr, d});
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                             input logic pbit, input logic stop);
      logic [11:0] bits;
      int nb;
      @(negedge clk);
      parity_en   = pen;
      parity_type = ptype;
      build_frame(d, pen, pbit, stop, bits, nb);
      drive_bits(bits, 0, nb);
      @(negedge clk);
      rxd = 1'b1;
      wait_ticks(4);
      model_frame(d, pen, ptype, pbit, stop);
   endtask

   task automatic pop();
      @(negedge clk);
      bus.read_en = 1'b1;
      @(negedge clk);
      bus.read_en = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic check_state(input string tag);
      logic [9:0] e;
      int lim;
      @(negedge clk);
      e   = (mq.size() != 0) ? mq[0] : 10'd0;
      lim = 8 - 2 * int'(bus.rx_thr_val);
      check({tag, ".data"},  bus.data_out,   e[7:0]);
      check({tag, ".perr"},  bus.parity_err, e[8]);
      check({tag, ".ferr"},  bus.frame_err,  e[9]);
      check({tag, ".empty"}, bus.rx_empty,   mq.size() == 0);
      check({tag, ".full"},  bus.rx_full,    mq.size() == 16);
      check({tag, ".ovr"},   bus.overrun,    m_ovr);
      check({tag, ".thr"},   bus.rx_thr,     mq.size() > lim);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       pen, ptype, pbit, stop;
      logic [7:0] e_data;
      logic       e_perr, e_ferr;
   } vec_t;

   vec_t vt[6];

   initial begin
      logic [11:0] bits;
      int nb;

      vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vt[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
      vt[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0};
      vt[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
      vt[4] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
      vt[5] = '{8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0};

      resetn = 1'b0; rx_en = 1'b1; parity_en = 1'b0; parity_type = 1'b0;
      bus.read_en = 1'b0; bus.rx_thr_val = 2'b00; bus.err_clr = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst.empty", bus.rx_empty, 1);
      check("rst.full",  bus.rx_full, 0);
      check("rst.thr",   bus.rx_thr, 0);
      check("rst.bclk_en", rx_bclk_en, 0);
      check("rst.data",  bus.data_out, 0);
      check("rst.ovr",   bus.overrun, 0);
      check("rst.perr",  bus.parity_err, 0);
      check("rst.ferr",  bus.frame_err, 0);
      resetn = 1'b1;
      wait_ticks(4);

      // Table-driven single frames
      for (int i = 0; i < 6; i++) begin
         send_frame(vt[i].d, vt[i].pen, vt[i].ptype, vt[i].pbit, vt[i].stop);
         @(negedge clk);
         check($sformatf("vec%0d.data", i),  bus.data_out,   vt[i].e_data);
         check($sformatf("vec%0d.perr", i),  bus.parity_err, vt[i].e_perr);
         check($sformatf("vec%0d.ferr", i),  bus.frame_err,  vt[i].e_ferr);
         check($sformatf("vec%0d.empty", i), bus.rx_empty,   0);
         pop();
         check($sformatf("vec%0d.popped", i), bus.rx_empty,  1);
      end

      // False start: short low pulse
      @(negedge clk); rxd = 1'b0;
      wait_ticks(4);
      @(negedge clk);
      check("fs.busy", rx_bclk_en, 1);
      rxd = 1'b1;
      wait_ticks(16);
      @(negedge clk);
      check("fs.idle", rx_bclk_en, 0);
      check("fs.empty", bus.rx_empty, 1);

      // Fill to full and overflow
      for (int i = 1; i <= 17; i++) begin
         send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         if (i == 16) begin
            @(negedge clk);
            check("ovf.full16", bus.rx_full, 1);
            check("ovf.ovr16",  bus.overrun, 0);
         end
      end
      check_state("ovf17");
      check("ovf.head", bus.data_out, 8'd1);
      @(negedge clk); bus.err_clr = 1'b1;
      @(negedge clk); bus.err_clr = 1'b0;
      m_ovr = 1'b0;
      check("ovf.clr", bus.overrun, 0);
      while (mq.size() != 0) begin
         check_state("drain");
         pop();
      end
      check_state("drained");

      // Threshold select 10 (>4)
      @(negedge clk); bus.rx_thr_val = 2'b10;
      for (int i = 0; i < 5; i++) begin
         send_frame(8'h30 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
         if (i == 3) begin @(negedge clk); check("thr.four", bus.rx_thr, 0); end
      end
      @(negedge clk);
      check("thr.five", bus.rx_thr, 1);
      pop();
      check("thr.pop", bus.rx_thr, 0);

      // rx_en dropped mid-frame: frame discarded, FIFO untouched
      build_frame(8'h3C, 1'b0, 1'b0, 1'b1, bits, nb);
      drive_bits(bits, 0, 4);
      @(negedge clk);
      check("dis.busy", rx_bclk_en, 1);
      rx_en = 1'b0;
      @(negedge clk);
      check("dis.idle", rx_bclk_en, 0);
      drive_bits(bits, 4, nb - 4);
      @(negedge clk); rxd = 1'b1;
      wait_ticks(4);
      @(negedge clk); rx_en = 1'b1;
      wait_ticks(4);
      check_state("dis");

      // Reset mid-frame
      build_frame(8'hC3, 1'b0, 1'b0, 1'b1, bits, nb);
      drive_bits(bits, 0, 5);
      @(negedge clk); resetn = 1'b0;
      @(negedge clk);
      check("rstm.idle",  rx_bclk_en, 0);
      check("rstm.empty", bus.rx_empty, 1);
      drive_bits(bits, 5, nb - 5);
      @(negedge clk); rxd = 1'b1;
      wait_ticks(4);
      @(negedge clk); resetn = 1'b1;
      mq.delete();
      m_ovr = 1'b0;
      wait_ticks(4);
      check_state("rstm");

      // Randomised frames against the model
      for (int n = 0; n < 20; n++) begin
         logic [7:0] d;
         logic pen, ptype, pbit, stop;
         int ones;
         d     = 8'($urandom);
         pen   = 1'($urandom);
         ptype = 1'($urandom);
         ones  = $countones(d);
         pbit  = (ptype ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ ($urandom_range(0, 3) == 0);
         stop  = ($urandom_range(0, 7) != 0);
         @(negedge clk); bus.rx_thr_val = 2'($urandom);
         send_frame(d, pen, ptype, pbit, stop);
         check_state($sformatf("rnd%0d", n));
         for (int k = $urandom_range(0, 2); k > 0 || mq.size() >= 14; k--) begin
            pop();
            check_state($sformatf("rnd%0d.pop", n));
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
